fault_campaign_seq: RTL

- Sequencer that runs a stuck-at fault campaign over the fault-injectable gate netlist.
- Per fault: selects one registered stuck-at site, drives a test-vector sweep into the faulted instance, and compares its outputs against a fault-free golden instance fed the same vectors.
- Reports per-fault detection and totals.
- Sits directly upstream of the faulted gate cells: it produces the fault selection that drives their stuck_* controls, plus the shared stimulus.

---
 rtl/fault_pkg.sv | 28 ++
 rtl/fault_campaign_seq_cmp_pipe.sv | 54 +++++
 rtl/fault_campaign_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fault_pkg.sv
//------------------------------------------------------------------------------
// fault_pkg : shared types and default sizing for the stuck-at fault campaign
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fault_pkg;

  localparam int c_NFAULTS = 64;
  localparam int c_FW      = 6;
  localparam int c_VW      = 8;
  localparam int c_OW      = 8;
  localparam int c_LAT     = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  typedef logic [c_FW-1:0] fault_idx_t;

endpackage

`default_nettype wire

// File: rtl/fault_campaign_seq_cmp_pipe.sv
//------------------------------------------------------------------------------
// cmp_pipe : LAT-deep valid line aligned to the instance latency, plus the
//            sticky golden-vs-faulted mismatch flag
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_pipe
  import fault_pkg::*;
#(
  parameter int OW  = c_OW,
  parameter int LAT = c_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [OW-1:0] dut_i,
  input  logic [OW-1:0] gold_i,
  output logic          flag_o,
  output logic          flag_next_o
);

  logic [LAT-1:0] line_q;
  logic [LAT-1:0] line_d;
  logic           flag_q;
  logic           w_hit;

  generate
    if (LAT == 1) begin : g_lat_one
      assign line_d = push_i;
    end else begin : g_lat_multi
      assign line_d = {line_q[LAT-2:0], push_i};
    end
  endgenerate

  // Only entries that were pushed during RUN carry a meaningful compare.
  assign w_hit       = line_q[LAT-1] && (dut_i != gold_i);
  assign flag_next_o = flag_q | w_hit;
  assign flag_o      = flag_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      line_q <= '0;
      flag_q <= 1'b0;
    end else begin
      line_q <= line_d;
      flag_q <= flag_next_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fault_campaign_seq.sv
//------------------------------------------------------------------------------
// fault_campaign_seq : walks every stuck-at site, sweeps all stimulus vectors
//                      and reports per-fault detection plus running totals
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fault_campaign_seq
  import fault_pkg::*;
#(
  parameter int NFAULTS = c_NFAULTS,
  parameter int FW      = c_FW,
  parameter int VW      = c_VW,
  parameter int OW      = c_OW,
  parameter int LAT     = c_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] fault_sel,
  output logic          fault_en,
  output logic [VW-1:0] vec,
  input  logic [OW-1:0] dut_out,
  input  logic [OW-1:0] gold_out,
  output logic          det_valid,
  output logic [FW-1:0] det_idx,
  output logic          det_hit,
  output logic [FW:0]   det_cnt,
  output logic [FW:0]   und_cnt
);

  localparam int            c_DW          = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(LAT - 1);
  localparam logic [VW-1:0] c_VEC_LAST    = {VW{1'b1}};
  localparam logic [FW-1:0] c_LAST_FAULT  = FW'(NFAULTS - 1);
  localparam logic [FW:0]   c_CNT_MAX     = (FW+1)'(NFAULTS);

  state_e          state_q;
  logic [c_DW-1:0] drain_q;
  logic            busy_q;
  logic            done_q;
  logic [FW-1:0]   fault_sel_q;
  logic            fault_en_q;
  logic [VW-1:0]   vec_q;
  logic            det_valid_q;
  logic [FW-1:0]   det_idx_q;
  logic            det_hit_q;
  logic [FW:0]     det_cnt_q;
  logic [FW:0]     und_cnt_q;

  logic            w_push;
  logic            w_clear;
  logic            w_flag;
  logic            w_flag_next;

  assign w_push  = (state_q == ST_RUN);
  assign w_clear = (state_q == ST_ARM);

  cmp_pipe #(
    .OW  (OW),
    .LAT (LAT)
  ) u_cmp_pipe (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (w_clear),
    .push_i      (w_push),
    .dut_i       (dut_out),
    .gold_i      (gold_out),
    .flag_o      (w_flag),
    .flag_next_o (w_flag_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_sel_q <= '0;
      fault_en_q  <= 1'b0;
      vec_q       <= '0;
      det_valid_q <= 1'b0;
      det_idx_q   <= '0;
      det_hit_q   <= 1'b0;
      det_cnt_q   <= '0;
      und_cnt_q   <= '0;
    end else begin
      det_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fault_sel_q <= '0;
            det_cnt_q   <= '0;
            und_cnt_q   <= '0;
            busy_q      <= 1'b1;
            fault_en_q  <= 1'b1;
            vec_q       <= '0;
            state_q     <= ST_ARM;
          end
        end
        ST_ARM: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // The registered flag means a mismatch is already known; stop sweeping.
          if (vec_q == c_VEC_LAST || w_flag) begin
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            vec_q <= vec_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == c_DRAIN_LAST) begin
            fault_en_q  <= 1'b0;
            det_valid_q <= 1'b1;
            det_idx_q   <= fault_sel_q;
            det_hit_q   <= w_flag_next;
            if (w_flag_next) begin
              if (det_cnt_q < c_CNT_MAX) det_cnt_q <= det_cnt_q + 1'b1;
            end else begin
              if (und_cnt_q < c_CNT_MAX) und_cnt_q <= und_cnt_q + 1'b1;
            end
            state_q <= ST_REPORT;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_REPORT: begin
          if (fault_sel_q == c_LAST_FAULT) begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            fault_sel_q <= fault_sel_q + 1'b1;
            fault_en_q  <= 1'b1;
            vec_q       <= '0;
            state_q     <= ST_ARM;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault_sel = fault_sel_q;
  assign fault_en  = fault_en_q;
  assign vec       = vec_q;
  assign det_valid = det_valid_q;
  assign det_idx   = det_idx_q;
  assign det_hit   = det_hit_q;
  assign det_cnt   = det_cnt_q;
  assign und_cnt   = und_cnt_q;

endmodule

`default_nettype wire
